// File: rtl/control_ciclo_trabajo.sv
// Push-button front end for the DPWM modulator: synchronizes and debounces both buttons, then
// turns presses into single or auto-repeat steps of a saturating duty setpoint with an update strobe.
//   state  | meaning
//   IDLE   | no active request, waiting for a fresh stable press
//   HOLD   | first step taken, timing the delay before auto-repeat
//   REPEAT | auto-repeat running, one step every REPEAT_PERIOD cycles
module control_ciclo_trabajo #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000,
    parameter int unsigned DUTY_WIDTH      = 4,
    parameter int unsigned DUTY_MAX        = 15,
    parameter int unsigned DUTY_RESET      = 8
) (
    input  logic                  CLK_FPGA_BOARD,
    input  logic                  reinicio,
    input  logic                  boton_aumentar,
    input  logic                  boton_disminuir,
    output logic [DUTY_WIDTH-1:0] ciclo_trabajo,
    output logic                  actualizar,
    output logic                  limite
);

    localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX);

    localparam logic [DUTY_WIDTH-1:0] DUTY_TOP   = DUTY_WIDTH'(DUTY_MAX);
    localparam logic [DUTY_WIDTH-1:0] DUTY_INIT  = DUTY_WIDTH'(DUTY_RESET);
    localparam logic                  LIMIT_INIT = (DUTY_RESET == 0) || (DUTY_RESET == DUTY_MAX);
    localparam logic [DB_W-1:0]       DB_LAST    = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [TMR_W-1:0]      DELAY_LAST = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0]      PER_LAST   = TMR_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    // Bit 0 carries boton_aumentar, bit 1 carries boton_disminuir.
    logic [1:0]           sync1_q, sync2_q;
    logic [1:0]           stable_q, stable_d;
    logic [1:0]           prev_q;
    logic [1:0][DB_W-1:0] db_cnt_q, db_cnt_d;

    state_t               state_q, state_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic                 dir_up_q, dir_up_d;
    logic [DUTY_WIDTH-1:0] duty_q, duty_d;
    logic                 act_q, act_d;
    logic                 lim_q, lim_d;

    logic [1:0] rise;
    logic       req_up, req_dn, req_ok, step;

    always_comb begin
        stable_d = stable_q;
        db_cnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    stable_d[i] = ~stable_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign rise   = stable_q & ~prev_q;
    assign req_up = stable_q[0] & ~stable_q[1];
    assign req_dn = stable_q[1] & ~stable_q[0];
    assign req_ok = dir_up_q ? req_up : req_dn;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        dir_up_d = dir_up_q;
        step     = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise[0] && !stable_q[1]) begin
                    step     = 1'b1;
                    dir_up_d = 1'b1;
                    timer_d  = '0;
                    state_d  = HOLD;
                end else if (rise[1] && !stable_q[0]) begin
                    step     = 1'b1;
                    dir_up_d = 1'b0;
                    timer_d  = '0;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (!req_ok) begin
                    state_d = IDLE;
                end else if (timer_q == DELAY_LAST) begin
                    step    = 1'b1;
                    timer_d = '0;
                    state_d = REPEAT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            REPEAT: begin
                if (!req_ok) begin
                    state_d = IDLE;
                end else if (timer_q == PER_LAST) begin
                    step    = 1'b1;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A step at a rail is swallowed: no value change and no strobe.
    always_comb begin
        duty_d = duty_q;
        act_d  = 1'b0;
        if (step) begin
            if (dir_up_d && (duty_q < DUTY_TOP)) begin
                duty_d = duty_q + 1'b1;
                act_d  = 1'b1;
            end else if (!dir_up_d && (duty_q != '0)) begin
                duty_d = duty_q - 1'b1;
                act_d  = 1'b1;
            end
        end
        lim_d = (duty_d == '0) || (duty_d == DUTY_TOP);
    end

    always_ff @(posedge CLK_FPGA_BOARD or negedge reinicio) begin
        if (!reinicio) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            prev_q   <= '0;
            db_cnt_q <= '0;
            state_q  <= IDLE;
            timer_q  <= '0;
            dir_up_q <= 1'b0;
            duty_q   <= DUTY_INIT;
            act_q    <= 1'b0;
            lim_q    <= LIMIT_INIT;
        end else begin
            sync1_q  <= {boton_disminuir, boton_aumentar};
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            prev_q   <= stable_q;
            db_cnt_q <= db_cnt_d;
            state_q  <= state_d;
            timer_q  <= timer_d;
            dir_up_q <= dir_up_d;
            duty_q   <= duty_d;
            act_q    <= act_d;
            lim_q    <= lim_d;
        end
    end

    assign ciclo_trabajo = duty_q;
    assign actualizar    = act_q;
    assign limite        = lim_q;

endmodule

// File: tb/tb_control_ciclo_trabajo.sv
// Directed bench for control_ciclo_trabajo with short debounce/repeat timing; edge numbers count
// from the first rising edge that samples a new button level (edge 0).
module tb_control_ciclo_trabajo;

    logic       clk;
    logic       rst_n;
    logic       up;
    logic       dn;
    logic [3:0] duty;
    logic       act;
    logic       lim;

    int errors = 0;
    int checks = 0;
    int e      = 0;
    int act_cnt = 0;
    int dbl    = 0;
    int base;
    logic act_prev = 1'b0;

    control_ciclo_trabajo #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8),
        .DUTY_WIDTH     (4),
        .DUTY_MAX       (15),
        .DUTY_RESET     (8)
    ) dut (
        .CLK_FPGA_BOARD (clk),
        .reinicio       (rst_n),
        .boton_aumentar (up),
        .boton_disminuir(dn),
        .ciclo_trabajo  (duty),
        .actualizar     (act),
        .limite         (lim)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (act) act_cnt++;
        if (act && act_prev) dbl++;
        act_prev = act;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            e++;
        end
    endtask

    task automatic goto_edge(input int t);
        if (t > e) adv(t - e);
    endtask

    task automatic chk_state(input string tag, input int d, input int a, input int l);
        chk({tag, "_duty"}, {28'd0, duty}, d);
        chk({tag, "_act"},  {31'd0, act},  a);
        chk({tag, "_lim"},  {31'd0, lim},  l);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        adv(2);
        rst_n = 1'b1;
        adv(2);
    endtask

    initial begin
        rst_n = 1'b1;
        up    = 1'b0;
        dn    = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_state("in_reset", 8, 0, 0);
        adv(3);
        rst_n = 1'b1;
        base = act_cnt;
        adv(30);
        chk_state("idle_after_reset", 8, 0, 0);
        chk("idle_no_pulse", act_cnt - base, 0);

        // Bouncy glitches, none longer than 3 cycles.
        base = act_cnt;
        up = 1'b1; adv(1); up = 1'b0; adv(1);
        up = 1'b1; adv(2); up = 1'b0; adv(1);
        up = 1'b1; adv(3); up = 1'b0; adv(2);
        up = 1'b1; adv(1); up = 1'b0; adv(1);
        up = 1'b1; adv(3); up = 1'b0; adv(1);
        up = 1'b1; adv(2); up = 1'b0; adv(10);
        chk("glitch_duty", {28'd0, duty}, 8);
        chk("glitch_no_pulse", act_cnt - base, 0);

        // Clean press held for 10 cycles.
        base = act_cnt;
        up = 1'b1; e = -1;
        goto_edge(6);  chk_state("press_e6", 8, 0, 0);
        goto_edge(7);  chk_state("press_e7", 9, 1, 0);
        goto_edge(8);  chk_state("press_e8", 9, 0, 0);
        goto_edge(9);  up = 1'b0;
        goto_edge(40); chk_state("press_done", 9, 0, 0);
        chk("press_one_pulse", act_cnt - base, 1);

        // Auto-repeat up to saturation.
        do_reset();
        base = act_cnt;
        up = 1'b1; e = -1;
        goto_edge(7);   chk_state("rep_e7", 9, 1, 0);
        goto_edge(26);  chk_state("rep_e26", 9, 0, 0);
        goto_edge(27);  chk_state("rep_e27", 10, 1, 0);
        goto_edge(34);  chk_state("rep_e34", 10, 0, 0);
        goto_edge(35);  chk_state("rep_e35", 11, 1, 0);
        goto_edge(43);  chk_state("rep_e43", 12, 1, 0);
        goto_edge(66);  chk_state("rep_e66", 14, 0, 0);
        goto_edge(67);  chk_state("rep_e67", 15, 1, 1);
        goto_edge(110); chk_state("rep_sat", 15, 0, 1);
        chk("rep_pulses", act_cnt - base, 7);
        up = 1'b0;
        adv(20);

        // Hold down from 15 to the lower rail.
        base = act_cnt;
        dn = 1'b1; e = -1;
        goto_edge(7);   chk_state("down_e7", 14, 1, 0);
        goto_edge(27);  chk_state("down_e27", 13, 1, 0);
        goto_edge(130); chk_state("down_e130", 1, 0, 0);
        goto_edge(131); chk_state("down_e131", 0, 1, 1);
        goto_edge(170); chk_state("down_sat", 0, 0, 1);
        chk("down_pulses", act_cnt - base, 15);
        dn = 1'b0;
        adv(20);
        up = 1'b1; e = -1;
        goto_edge(7);  chk_state("up_from0", 1, 1, 0);
        goto_edge(9);  up = 1'b0;
        adv(20);

        // Second button during HOLD cancels; held button gives no step on the other's release.
        base = act_cnt;
        up = 1'b1; e = -1;
        goto_edge(7);   chk_state("both_e7", 2, 1, 0);
        goto_edge(9);   dn = 1'b1;
        goto_edge(39);  chk("both_no_repeat", {28'd0, duty}, 2);
        up = 1'b0;
        goto_edge(69);  chk("held_no_step", {28'd0, duty}, 2);
        chk("both_pulses", act_cnt - base, 1);
        dn = 1'b0;
        goto_edge(89);  dn = 1'b1;
        goto_edge(96);  chk_state("repress_e96", 2, 0, 0);
        goto_edge(97);  chk_state("repress_e97", 1, 1, 0);
        goto_edge(100); dn = 1'b0;
        adv(20);

        // Reset in the middle of auto-repeat with the button still held.
        do_reset();
        up = 1'b1; e = -1;
        goto_edge(43); chk_state("rst_rep_e43", 12, 1, 0);
        goto_edge(46);
        rst_n = 1'b0;
        #1;
        chk_state("rst_async", 8, 0, 0);
        adv(3);
        chk_state("rst_held", 8, 0, 0);
        rst_n = 1'b1; e = -1;
        goto_edge(6);  chk_state("rst_rel_e6", 8, 0, 0);
        goto_edge(7);  chk_state("rst_rel_e7", 9, 1, 0);
        up = 1'b0;
        adv(20);

        chk("no_double_pulse", dbl, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
